pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 47 ++++
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard/handshake bundle between the pipeline datapath and pipeline_ctrl.
// The master side is the datapath; the slave side is the hazard controller.
interface pipeline_ctrl_if;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [4:0] RdM;
    logic [4:0] RdW;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       LoadE;
    logic       PCSrcE;
    logic       MemReqM;
    logic       MemReadyM;

    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushD;
    logic       FlushE;
    logic       FlushW;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       Halt;

    // Memory handshake: a request is outstanding while MemReqM is high and
    // completes in the cycle MemReadyM is sampled high; MemReqM/MemReadyM are
    // level signals, no transfer occurs when MemReqM is low.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, Halt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, Halt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard unit for a 5-stage pipeline: forwarding, load-use, branch flush and a
// memory-wait FSM with timeout halt. Optional stall counter: PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_ctrl_if.slave       io_hz,
    output logic [1:0]           o_dbg_state
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] StallCount
`endif
);

    localparam int WCW_RAW = $clog2(TIMEOUT + 1);
    localparam int WCW     = (WCW_RAW > 8) ? WCW_RAW : 8;
    localparam logic [WCW-1:0] TIMEOUT_CNT = WCW'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [WCW-1:0] r_wait_cnt;
    logic [WCW-1:0] w_wait_cnt_next;

    logic w_mem_busy;
    logic w_lu;
    logic w_hold;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Forwarding is purely combinational and ignores stalls and FSM state.
    assign io_hz.ForwardAE = fwd_sel(io_hz.Rs1E, io_hz.RdM, io_hz.RegWriteM,
                                     io_hz.RdW, io_hz.RegWriteW);
    assign io_hz.ForwardBE = fwd_sel(io_hz.Rs2E, io_hz.RdM, io_hz.RegWriteM,
                                     io_hz.RdW, io_hz.RegWriteW);

    assign w_mem_busy = io_hz.MemReqM & ~io_hz.MemReadyM;

    assign w_lu = io_hz.LoadE && (io_hz.RdE != 5'd0) &&
                  ((io_hz.RdE == io_hz.Rs1D) || (io_hz.RdE == io_hz.Rs2D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Ready is checked before the timeout so a late ready still returns to RUN.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            RUN: begin
                w_wait_cnt_next = '0;
                if (w_mem_busy) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (io_hz.MemReadyM) begin
                    w_state_next    = RUN;
                    w_wait_cnt_next = '0;
                end else if (w_mem_busy && (r_wait_cnt == TIMEOUT_CNT)) begin
                    w_state_next = ERR;
                end else if (r_wait_cnt != TIMEOUT_CNT) begin
                    w_wait_cnt_next = r_wait_cnt + WCW'(1);
                end
            end
            ERR: begin
                w_state_next = ERR;
            end
            default: begin
                w_state_next    = RUN;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    assign w_hold = w_mem_busy || (r_state == ERR);

    // A memory hold or error freezes the whole pipe and overrides hazards.
    always_comb begin
        io_hz.StallF = 1'b0;
        io_hz.StallD = 1'b0;
        io_hz.StallE = 1'b0;
        io_hz.StallM = 1'b0;
        io_hz.FlushD = 1'b0;
        io_hz.FlushE = 1'b0;
        io_hz.FlushW = 1'b0;
        if (w_hold) begin
            io_hz.StallF = 1'b1;
            io_hz.StallD = 1'b1;
            io_hz.StallE = 1'b1;
            io_hz.StallM = 1'b1;
            io_hz.FlushW = 1'b1;
        end else begin
            io_hz.StallF = w_lu & ~io_hz.PCSrcE;
            io_hz.StallD = w_lu & ~io_hz.PCSrcE;
            io_hz.FlushD = io_hz.PCSrcE;
            io_hz.FlushE = w_lu | io_hz.PCSrcE;
        end
    end

    assign io_hz.Halt  = (r_state == ERR);
    assign o_dbg_state = r_state;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (io_hz.StallF && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign StallCount = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: forwarding, load-use, memory wait,
// timeout halt and asynchronous reset, TIMEOUT = 4 and CNT_WIDTH = 4.
module tb_pipeline_ctrl;

  localparam int TIMEOUT   = 4;
  localparam int CNT_WIDTH = 4;
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] stall_count;
`endif

  int n_checks;
  int n_pass;

  pipeline_ctrl_if hz();

  pipeline_ctrl #(
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_hz       (hz.slave),
    .o_dbg_state (dbg_state)
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    .StallCount  (stall_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctl_vec();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
            hz.FlushW, hz.FlushD, hz.FlushE};
  endfunction

  task automatic clear_inputs();
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0;
    hz.Rs1E = 5'd0; hz.Rs2E = 5'd0; hz.RdE = 5'd0;
    hz.RdM  = 5'd0; hz.RdW  = 5'd0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.LoadE = 1'b0; hz.PCSrcE = 1'b0;
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  // leaves time at posedge + 1
  task automatic do_reset();
    clear_inputs();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (dbg_state !== S_RUN) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_RUN);
    else n_pass++;
    n_checks++;
    if (hz.Halt !== 1'b0) $display("FAIL reset_halt got=%b exp=0", hz.Halt);
    else n_pass++;
    n_checks++;
    if (ctl_vec() !== 7'b0) $display("FAIL reset_ctl got=%b exp=0000000", ctl_vec());
    else n_pass++;
`ifdef PIPELINE_CTRL_PERF_EN
    n_checks++;
    if (stall_count !== '0) $display("FAIL reset_stallcount got=%0d exp=0", stall_count);
    else n_pass++;
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_forwarding();
    hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
    hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
    hz.Rs1E = 5'd5; hz.Rs2E = 5'd9;
    #1;
    n_checks++;
    if (hz.ForwardAE !== 2'b10) $display("FAIL fwd_a_m_prio got=%b exp=10", hz.ForwardAE);
    else n_pass++;
    n_checks++;
    if (hz.ForwardBE !== 2'b00) $display("FAIL fwd_b_nomatch got=%b exp=00", hz.ForwardBE);
    else n_pass++;
    hz.RegWriteM = 1'b0;
    #1;
    n_checks++;
    if (hz.ForwardAE !== 2'b01) $display("FAIL fwd_a_w got=%b exp=01", hz.ForwardAE);
    else n_pass++;
    hz.Rs1E = 5'd0; hz.RdM = 5'd0; hz.RegWriteM = 1'b1;
    #1;
    n_checks++;
    if (hz.ForwardAE !== 2'b00) $display("FAIL fwd_a_x0 got=%b exp=00", hz.ForwardAE);
    else n_pass++;
    hz.RdM = 5'd9;
    #1;
    n_checks++;
    if (hz.ForwardBE !== 2'b10) $display("FAIL fwd_b_m got=%b exp=10", hz.ForwardBE);
    else n_pass++;
    hz.RdM = 5'd3; hz.RdW = 5'd9;
    #1;
    n_checks++;
    if (hz.ForwardBE !== 2'b01) $display("FAIL fwd_b_w got=%b exp=01", hz.ForwardBE);
    else n_pass++;
    hz.RegWriteW = 1'b0;
    #1;
    n_checks++;
    if (hz.ForwardBE !== 2'b00) $display("FAIL fwd_b_wen0 got=%b exp=00", hz.ForwardBE);
    else n_pass++;
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_load_use();
    hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.Rs1D = 5'd2; hz.PCSrcE = 1'b0;
    @(negedge clk);
    n_checks++;
    // {StallF,StallD,StallE,StallM,FlushW,FlushD,FlushE}
    if (ctl_vec() !== 7'b1100001) $display("FAIL lu_rs2 got=%b exp=1100001", ctl_vec());
    else n_pass++;
    hz.PCSrcE = 1'b1;
    #1;
    n_checks++;
    if (ctl_vec() !== 7'b0000011) $display("FAIL lu_branch got=%b exp=0000011", ctl_vec());
    else n_pass++;
    hz.PCSrcE = 1'b0; hz.Rs2D = 5'd1; hz.Rs1D = 5'd7;
    #1;
    n_checks++;
    if (ctl_vec() !== 7'b1100001) $display("FAIL lu_rs1 got=%b exp=1100001", ctl_vec());
    else n_pass++;
    hz.RdE = 5'd0; hz.Rs1D = 5'd0;
    #1;
    n_checks++;
    if (ctl_vec() !== 7'b0000000) $display("FAIL lu_x0 got=%b exp=0000000", ctl_vec());
    else n_pass++;
    hz.RdE = 5'd7; hz.Rs1D = 5'd7; hz.LoadE = 1'b0; hz.PCSrcE = 1'b1;
    #1;
    n_checks++;
    if (ctl_vec() !== 7'b0000011) $display("FAIL branch_only got=%b exp=0000011", ctl_vec());
    else n_pass++;
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_mem_wait();
    logic [1:0] st_seen;
    do_reset();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    // a concurrent load-use must be overridden by the memory hold
    hz.LoadE = 1'b1; hz.RdE = 5'd4; hz.Rs1D = 5'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctl_vec() !== 7'b1111100) $display("FAIL memwait_ctl[%0d] got=%b exp=1111100", i, ctl_vec());
      else n_pass++;
      next_cycle();
    end
    st_seen = dbg_state;
    n_checks++;
    if (st_seen !== S_WAIT) $display("FAIL memwait_state got=%0d exp=%0d", st_seen, S_WAIT);
    else n_pass++;
    hz.MemReadyM = 1'b1; hz.LoadE = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctl_vec() !== 7'b0000000) $display("FAIL memready_ctl got=%b exp=0000000", ctl_vec());
    else n_pass++;
    next_cycle();
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== S_RUN) $display("FAIL memwait_return got=%0d exp=%0d", dbg_state, S_RUN);
    else n_pass++;
`ifdef PIPELINE_CTRL_PERF_EN
    n_checks++;
    if (stall_count !== 4'd3) $display("FAIL memwait_stallcount got=%0d exp=3", stall_count);
    else n_pass++;
`endif
    next_cycle();
  endtask

  task automatic test_timeout();
    do_reset();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    // one RUN cycle then WAIT with count 0..4; ERR after the sixth edge
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clk);
    n_checks++;
    if (hz.Halt !== 1'b0) $display("FAIL timeout_early got=%b exp=0", hz.Halt);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (hz.Halt !== 1'b1) $display("FAIL timeout_halt got=%b exp=1", hz.Halt);
    else n_pass++;
    n_checks++;
    if (dbg_state !== S_ERR) $display("FAIL timeout_state got=%0d exp=%0d", dbg_state, S_ERR);
    else n_pass++;
    hz.MemReadyM = 1'b1;
    hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.Rs1E = 5'd5;
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk);
    n_checks++;
    if (hz.Halt !== 1'b1) $display("FAIL halt_sticky got=%b exp=1", hz.Halt);
    else n_pass++;
    n_checks++;
    if (ctl_vec() !== 7'b1111100) $display("FAIL err_ctl got=%b exp=1111100", ctl_vec());
    else n_pass++;
    n_checks++;
    if (hz.ForwardAE !== 2'b10) $display("FAIL err_fwd got=%b exp=10", hz.ForwardAE);
    else n_pass++;
    // asynchronous reset between edges
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (hz.Halt !== 1'b0) $display("FAIL async_halt got=%b exp=0", hz.Halt);
    else n_pass++;
    n_checks++;
    if (dbg_state !== S_RUN) $display("FAIL async_state got=%0d exp=%0d", dbg_state, S_RUN);
    else n_pass++;
    clear_inputs();
    #1 rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) next_cycle();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dbg_state !== S_RUN) $display("FAIL midwait_state got=%0d exp=%0d", dbg_state, S_RUN);
    else n_pass++;
    n_checks++;
    if (ctl_vec() !== 7'b1111100) $display("FAIL midwait_busy_ctl got=%b exp=1111100", ctl_vec());
    else n_pass++;
    #1 rst_n = 1'b1;
    // counter restarts from zero: full timeout needed again
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clk);
    n_checks++;
    if (hz.Halt !== 1'b0) $display("FAIL midwait_cnt_clear got=%b exp=0", hz.Halt);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (hz.Halt !== 1'b1) $display("FAIL midwait_retimeout got=%b exp=1", hz.Halt);
    else n_pass++;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (ctl_vec() !== 7'b0000000) $display("FAIL post_reset_ctl got=%b exp=0000000", ctl_vec());
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_late_ready();
    do_reset();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    // after 5 edges the counter equals TIMEOUT; ready arrives in that cycle
    for (int i = 0; i < 5; i++) next_cycle();
    hz.MemReadyM = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (dbg_state !== S_RUN) $display("FAIL late_ready_state got=%0d exp=%0d", dbg_state, S_RUN);
    else n_pass++;
    n_checks++;
    if (hz.Halt !== 1'b0) $display("FAIL late_ready_halt got=%b exp=0", hz.Halt);
    else n_pass++;
    clear_inputs();
    next_cycle();
  endtask

`ifdef PIPELINE_CTRL_PERF_EN
  task automatic test_stall_saturate();
    do_reset();
    hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    for (int i = 0; i < 14; i++) next_cycle();
    @(negedge clk);
    n_checks++;
    if (stall_count !== 4'd14) $display("FAIL stallcount_14 got=%0d exp=14", stall_count);
    else n_pass++;
    for (int i = 0; i < 6; i++) next_cycle();
    @(negedge clk);
    n_checks++;
    if (stall_count !== 4'hF) $display("FAIL stallcount_sat got=%0d exp=15", stall_count);
    else n_pass++;
    clear_inputs();
    next_cycle();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_late_ready();
`ifdef PIPELINE_CTRL_PERF_EN
    test_stall_saturate();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
